// File: rtl/hazard_pkg.sv
// hazard_pkg: opcodes, forward-select encoding and shadow-entry type shared by the hazard unit.
package hazard_pkg;
  localparam logic [4:0] OP_ALU_LAST = 5'b01100;
  localparam logic [4:0] OP_CMP = 5'b00101;
  localparam logic [4:0] OP_NOT = 5'b01000;
  localparam logic [4:0] OP_MOV = 5'b01001;
  localparam logic [4:0] OP_NOP = 5'b01101;
  localparam logic [4:0] OP_LD = 5'b01110;
  localparam logic [4:0] OP_ST = 5'b01111;
  localparam logic [4:0] OP_BEQ = 5'b10000;
  localparam logic [4:0] OP_BGT = 5'b10001;
  localparam logic [4:0] OP_B = 5'b10010;
  localparam logic [4:0] OP_CALL = 5'b10011;
  localparam logic [4:0] OP_RET = 5'b10100;
  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_MA = 2'd1;
  localparam logic [1:0] FWD_RW = 2'd2;
  localparam int DEST_W = 8;
  typedef struct packed {
    logic valid;
    logic writes;
    logic [DEST_W-1:0] dest;
    logic is_load;
  } shadow_t;
endpackage

// File: rtl/hzd_decode.sv
// hzd_decode: combinational decode of destination, load flag and used source registers.
module hzd_decode import hazard_pkg::*; #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW = 4,
  parameter int RA_IDX = 15,
  parameter int IR_W = 32
) (
  input logic [IR_W-1:0] ir,
  output logic writes,
  output logic [REG_AW-1:0] dest,
  output logic is_load,
  output logic [NUM_SRC-1:0] used,
  output logic [NUM_SRC*REG_AW-1:0] idx
);
  logic [4:0] op;
  logic [REG_AW-1:0] rd, rs1, rs2, ra;
  logic unused_ir;
  assign op = ir[31:27];
  assign rd = ir[22 +: REG_AW];
  assign rs1 = ir[18 +: REG_AW];
  assign rs2 = ir[14 +: REG_AW];
  assign ra = REG_AW'(RA_IDX);
  assign unused_ir = ^ir;
  always_comb begin
    writes = !(op inside {OP_NOP, OP_CMP, OP_ST, OP_B, OP_BEQ, OP_BGT, OP_RET});
    dest = op == OP_CALL ? ra : rd;
    is_load = op == OP_LD;
    used = '0;
    idx = '0;
    used[0] = !(op inside {OP_NOP, OP_B, OP_BEQ, OP_BGT, OP_CALL, OP_MOV, OP_NOT});
    idx[REG_AW-1:0] = op == OP_RET ? ra : rs1;
    used[1] = !ir[26] && op <= OP_ALU_LAST;
    idx[2*REG_AW-1:REG_AW] = rs2;
    if (NUM_SRC > 2) begin
      used[NUM_SRC-1] = op == OP_ST;
      idx[(NUM_SRC-1)*REG_AW +: REG_AW] = rd;
    end
  end
endmodule

// File: rtl/operand_hazard_unit.sv
// operand_hazard_unit: EX/MA/RW destination shadow pipeline, registered forward selects and load-use stall.
// Optional HAZ_STALL_COUNT_EN adds a saturating stall_cnt output.
module operand_hazard_unit import hazard_pkg::*; #(
  parameter int NUM_SRC = 2,
  parameter int REG_AW = 4,
  parameter int RA_IDX = 15,
  parameter int IR_W = 32
) (
  input logic clk,
  input logic rst_n,
  input logic adv,
  input logic flush,
  input logic of_valid,
  input logic [IR_W-1:0] of_ir,
  output logic stall,
  output logic [2*NUM_SRC-1:0] ex_fwd_sel,
  output logic ex_valid,
  output logic ma_valid,
  output logic rw_valid
`ifdef HAZ_STALL_COUNT_EN
  , output logic [15:0] stall_cnt
`endif
);
  logic d_writes, d_load, load_ex, rw_q;
  logic [REG_AW-1:0] d_dest;
  logic [NUM_SRC-1:0] d_used, ex_hit, ma_hit;
  logic [NUM_SRC*REG_AW-1:0] d_idx;
  logic [2*NUM_SRC-1:0] sel_d;
  shadow_t ex_q, ma_q, of_e;
  hzd_decode #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .RA_IDX(RA_IDX), .IR_W(IR_W)) u_dec (
    .ir(of_ir),
    .writes(d_writes),
    .dest(d_dest),
    .is_load(d_load),
    .used(d_used),
    .idx(d_idx)
  );
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign ex_hit[i] = d_used[i] & ex_q.valid & ex_q.writes & (ex_q.dest == DEST_W'(d_idx[i*REG_AW +: REG_AW]));
    assign ma_hit[i] = d_used[i] & ma_q.valid & ma_q.writes & (ma_q.dest == DEST_W'(d_idx[i*REG_AW +: REG_AW]));
    // a load's data is produced by MA, so it is taken from the MA result path even one stage later
    assign sel_d[2*i +: 2] = ex_hit[i] ? FWD_MA : ma_hit[i] ? (ma_q.is_load ? FWD_MA : FWD_RW) : FWD_RF;
  end
  assign stall = of_valid & ~flush & ex_q.valid & ex_q.is_load & |ex_hit;
  assign load_ex = of_valid & ~flush & ~stall;
  assign of_e = '{valid: 1'b1, writes: d_writes, dest: DEST_W'(d_dest), is_load: d_load};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
      ma_q <= '0;
      rw_q <= 1'b0;
      ex_fwd_sel <= '0;
    end else if (adv) begin
      rw_q <= ma_q.valid;
      ma_q <= ex_q;
      ex_q <= load_ex ? of_e : '0;
      ex_fwd_sel <= load_ex ? sel_d : '0;
    end
  end
  assign ex_valid = ex_q.valid;
  assign ma_valid = ma_q.valid;
  assign rw_valid = rw_q;
`ifdef HAZ_STALL_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt <= '0;
    else if (stall & adv & ~&stall_cnt) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_operand_hazard_unit.sv
// tb_operand_hazard_unit: directed vectors checked against an instruction-history model plus literal expectations.
module tb_operand_hazard_unit;
  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, CMP = 5'b00101, NOT_ = 5'b01000, MOV = 5'b01001;
  localparam logic [4:0] NOP = 5'b01101, LD = 5'b01110, ST = 5'b01111, BEQ = 5'b10000, BGT = 5'b10001;
  localparam logic [4:0] BR = 5'b10010, CALL = 5'b10011, RET = 5'b10100;
  logic clk = 0, rst_n = 0, adv = 0, flush = 0, of_valid = 0;
  logic [31:0] of_ir = '0;
  logic stall, ex_valid, ma_valid, rw_valid;
  logic [3:0] ex_fwd_sel;
`ifdef HAZ_STALL_COUNT_EN
  logic [15:0] stall_cnt;
`endif
  always #5 clk = ~clk;
  operand_hazard_unit dut (
    .clk(clk), .rst_n(rst_n), .adv(adv), .flush(flush), .of_valid(of_valid), .of_ir(of_ir),
    .stall(stall), .ex_fwd_sel(ex_fwd_sel), .ex_valid(ex_valid), .ma_valid(ma_valid), .rw_valid(rw_valid)
`ifdef HAZ_STALL_COUNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  int total = 0, bad = 0;
  bit chk = 0, st_seen;
  logic [31:0] p_ir [3];
  bit p_v [3];
  logic [3:0] m_sel;
  int m_cnt;
  function automatic logic [31:0] mk(logic [4:0] op, bit i, logic [3:0] rd, logic [3:0] rs1, logic [3:0] rs2);
    return {op, i, rd, rs1, rs2, 14'b0};
  endfunction
  function automatic bit f_wr(logic [31:0] ir);
    logic [4:0] o = ir[31:27];
    return !(o inside {NOP, CMP, ST, BR, BEQ, BGT, RET});
  endfunction
  function automatic logic [3:0] f_dst(logic [31:0] ir);
    return ir[31:27] == CALL ? 4'd15 : ir[25:22];
  endfunction
  function automatic bit f_use(logic [31:0] ir, int s);
    logic [4:0] o = ir[31:27];
    if (s == 0) return !(o inside {NOP, BR, BEQ, BGT, CALL, MOV, NOT_});
    return !ir[26] && o <= 5'd12;
  endfunction
  function automatic logic [3:0] f_idx(logic [31:0] ir, int s);
    if (s == 0) return ir[31:27] == RET ? 4'd15 : ir[21:18];
    return ir[17:14];
  endfunction
  function automatic bit f_hit(int k, logic [31:0] ir, int s);
    return p_v[k] && f_wr(p_ir[k]) && f_use(ir, s) && f_dst(p_ir[k]) == f_idx(ir, s);
  endfunction
  function automatic bit m_stall();
    if (!of_valid || flush || !p_v[0] || p_ir[0][31:27] != LD) return 0;
    return f_hit(0, of_ir, 0) || f_hit(0, of_ir, 1);
  endfunction
  function automatic logic [3:0] m_next_sel();
    logic [3:0] r = '0;
    for (int s = 0; s < 2; s++)
      r[2*s +: 2] = f_hit(0, of_ir, s) ? 2'd1 : f_hit(1, of_ir, s) ? (p_ir[1][31:27] == LD ? 2'd1 : 2'd2) : 2'd0;
    return r;
  endfunction
  task automatic cmp(string n, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, got, exp, $time);
    end
  endtask
  task automatic m_reset();
    for (int k = 0; k < 3; k++) begin
      p_v[k] = 0;
      p_ir[k] = '0;
    end
    m_sel = '0;
    m_cnt = 0;
  endtask
  always @(negedge clk) begin
    if (chk && rst_n) begin
      cmp("stall", {31'b0, stall}, {31'b0, m_stall()});
      cmp("ex_fwd_sel", {28'b0, ex_fwd_sel}, {28'b0, m_sel});
      cmp("ex_valid", {31'b0, ex_valid}, {31'b0, p_v[0]});
      cmp("ma_valid", {31'b0, ma_valid}, {31'b0, p_v[1]});
      cmp("rw_valid", {31'b0, rw_valid}, {31'b0, p_v[2]});
`ifdef HAZ_STALL_COUNT_EN
      cmp("stall_cnt", {16'b0, stall_cnt}, m_cnt);
`endif
    end
  end
  task automatic cyc(input bit a, input bit f, input bit v, input logic [31:0] i);
    logic [3:0] ns;
    bit st, ld;
    adv = a;
    flush = f;
    of_valid = v;
    of_ir = i;
    @(negedge clk);
    st_seen = stall;
    st = m_stall();
    ns = m_next_sel();
    ld = v && !f && !st;
    @(posedge clk);
    #1;
    if (a) begin
      if (st && m_cnt < 65535) m_cnt++;
      p_v[2] = p_v[1]; p_ir[2] = p_ir[1];
      p_v[1] = p_v[0]; p_ir[1] = p_ir[0];
      p_v[0] = ld; p_ir[0] = i;
      m_sel = ld ? ns : 4'd0;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [4:0] ops [12] = '{ADD, SUB, CMP, MOV, NOT_, LD, ST, NOP, CALL, RET, BR, BEQ};
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    cmp("rst_ex_valid", {31'b0, ex_valid}, 0);
    cmp("rst_sel", {28'b0, ex_fwd_sel}, 0);
    cmp("rst_stall", {31'b0, stall}, 0);
    rst_n = 1;
    chk = 1;
    cyc(1, 0, 1, mk(ADD, 0, 1, 2, 3));
    cyc(1, 0, 1, mk(ADD, 0, 4, 1, 5));
    cmp("raw_ex_sel", {28'b0, ex_fwd_sel}, 4'b0001);
    cmp("raw_nostall", {31'b0, st_seen}, 0);
    cyc(1, 0, 1, mk(ADD, 0, 1, 2, 3));
    cyc(1, 0, 1, mk(NOP, 0, 0, 0, 0));
    cyc(1, 0, 1, mk(SUB, 0, 6, 7, 1));
    cmp("raw_ma_sel", {28'b0, ex_fwd_sel}, 4'b1000);
    cyc(1, 0, 1, mk(LD, 1, 1, 2, 0));
    cyc(1, 0, 1, mk(ADD, 0, 3, 1, 1));
    cmp("ldu_stall", {31'b0, st_seen}, 1);
    cmp("ldu_bubble", {31'b0, ex_valid}, 0);
    cyc(1, 0, 1, mk(ADD, 0, 3, 1, 1));
    cmp("ldu_release", {31'b0, st_seen}, 0);
    cmp("ldu_sel", {28'b0, ex_fwd_sel}, 4'b0101);
`ifdef HAZ_STALL_COUNT_EN
    cmp("cnt_one", {16'b0, stall_cnt}, 1);
`endif
    cyc(1, 0, 1, mk(ADD, 0, 9, 1, 2));
    cyc(1, 0, 1, mk(ADD, 1, 1, 10, 9));
    cmp("imm_no_src2", {28'b0, ex_fwd_sel}, 4'b0000);
    cyc(1, 0, 1, mk(CALL, 0, 0, 0, 0));
    cyc(1, 0, 1, mk(RET, 0, 0, 0, 0));
    cmp("ret_ra_sel", {28'b0, ex_fwd_sel}, 4'b0001);
    cyc(1, 0, 1, mk(LD, 1, 5, 2, 0));
    cyc(0, 0, 1, mk(ADD, 0, 6, 5, 5));
    cmp("frozen_stall", {31'b0, st_seen}, 1);
    cmp("frozen_ex", {31'b0, ex_valid}, 1);
    cyc(1, 1, 1, mk(ADD, 0, 6, 5, 5));
    cmp("flush_stall", {31'b0, st_seen}, 0);
    cmp("flush_bubble", {31'b0, ex_valid}, 0);
    cyc(1, 0, 1, mk(ADD, 0, 2, 0, 0));
    cyc(1, 0, 1, mk(ADD, 0, 2, 0, 0));
    cyc(1, 0, 1, mk(ADD, 0, 8, 2, 2));
    cmp("b2b_young", {28'b0, ex_fwd_sel}, 4'b0101);
    cyc(1, 0, 1, mk(LD, 1, 4, 2, 0));
    of_ir = mk(ADD, 0, 5, 4, 4);
    #1;
    cmp("pre_rst_stall", {31'b0, stall}, 1);
    #1;
    rst_n = 0;
    m_reset();
    #1;
    cmp("arst_stall", {31'b0, stall}, 0);
    cmp("arst_sel", {28'b0, ex_fwd_sel}, 0);
    cmp("arst_valid", {29'b0, ex_valid, ma_valid, rw_valid}, 0);
`ifdef HAZ_STALL_COUNT_EN
    cmp("arst_cnt", {16'b0, stall_cnt}, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1;
    for (int n = 0; n < 60; n++)
      cyc($urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) != 0,
          mk(ops[$urandom_range(0, 11)], 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
             4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))));
    chk = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
